spi_pixel_receive: RTL

- Main-FPGA SPI receiver; sits directly downstream of the peripheral FPGA's nibble-serial pixel sender.
- The sender produces:
  - CS low for one transaction;
  - the high nibble on CS fall, the low nibble on the first DCLK falling edge;
  - CS high on the second falling edge;
  - a final-pixel sideband flag.
- This block synchronizes those pins into clk_in, samples the data lines on DCLK rising edges and reassembles 8-bit pixels.
- It tags each pixel with raster coordinates and delivers pixels as single-cycle valid pulses to the frame-buffer writer.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_pixel_receive_if.sv | 27 ++
 rtl/spi_pixel_receive_sync_ff.sv | 22 ++
 rtl/spi_pixel_receive.sv | 101 ++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, raster defaults and coordinate widths for the SPI pixel receiver
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_t;
  localparam int H_ACTIVE_DEFAULT = 1280;
  localparam int V_ACTIVE_DEFAULT = 720;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
endpackage

// File: rtl/spi_pixel_receive_if.sv
// spi_pixel_receive_if: peripheral pins in, tagged pixel stream out
interface spi_pixel_receive_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINES = 4
);
  logic [LINES-1:0] chip_data_in;
  logic chip_clk_in;
  logic chip_sel_in;
  logic final_pixel_in;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic pixel_valid_out;
  logic [HCOUNT_W-1:0] hcount_out;
  logic [VCOUNT_W-1:0] vcount_out;
  logic frame_done_out;
  logic abort_out;
  logic [15:0] err_count_out;
  modport master (
    output chip_data_in, chip_clk_in, chip_sel_in, final_pixel_in,
    input pixel_out, pixel_valid_out, hcount_out, vcount_out, frame_done_out, abort_out, err_count_out
  );
  modport slave (
    input chip_data_in, chip_clk_in, chip_sel_in, final_pixel_in,
    output pixel_out, pixel_valid_out, hcount_out, vcount_out, frame_done_out, abort_out, err_count_out
  );
endinterface

// File: rtl/spi_pixel_receive_sync_ff.sv
// sync_ff: multi-stage synchronizer with a configurable reset value
module sync_ff #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [STAGES];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_pixel_receive.sv
// spi_pixel_receive: nibble-serial SPI pixel receiver with raster tagging; SPI_RX_ERR_COUNT_EN adds a saturating abort counter
module spi_pixel_receive
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINES = 4,
  parameter int SYNC_STAGES = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input logic clk_in,
  input logic rst_in,
  spi_pixel_receive_if.slave bus
);
  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int BW = $clog2(BEATS + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS);
  localparam logic [BW-1:0] PEN = BW'(BEATS - 1);
  localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);
  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_ACTIVE - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_ACTIVE - 1);
  logic [LINES-1:0] data_s;
  logic final_s, dclk_s, cs_s, dclk_prev, rise, settled, seen_cs_high, final_r, fire, abort;
  logic [SW-1:0] settle;
  logic [BW-1:0] beat;
  logic [DATA_WIDTH-1:0] shift;
  logic [HCOUNT_W-1:0] h;
  logic [VCOUNT_W-1:0] v;
  rx_state_t state, state_n;
  sync_ff #(.WIDTH(LINES + 1), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_data (
    .clk_in(clk_in), .rst_in(rst_in), .d({bus.final_pixel_in, bus.chip_data_in}), .q({final_s, data_s})
  );
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dclk (
    .clk_in(clk_in), .rst_in(rst_in), .d(bus.chip_clk_in), .q(dclk_s)
  );
  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_in(clk_in), .rst_in(rst_in), .d(bus.chip_sel_in), .q(cs_s)
  );
  assign rise = dclk_s & ~dclk_prev;
  // the CS chain resets high, so its output is not trusted until the reset value has flushed out
  assign settled = settle == SETTLED;
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE)  ? ((!cs_s && seen_cs_high) ? SHIFT : IDLE)
            : (state == SHIFT) ? ((beat == LAST) ? DONE : (cs_s && !rise) ? IDLE : SHIFT)
            : (cs_s ? IDLE : DONE);
  end
  always_comb begin
    fire = state == SHIFT && beat == LAST;
    abort = state == SHIFT && beat != LAST && cs_s && !rise;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dclk_prev <= 1'b0;
      settle <= '0;
      seen_cs_high <= 1'b0;
      beat <= '0;
      shift <= '0;
      final_r <= 1'b0;
      h <= '0;
      v <= '0;
      bus.pixel_out <= '0;
      bus.pixel_valid_out <= 1'b0;
      bus.hcount_out <= '0;
      bus.vcount_out <= '0;
      bus.frame_done_out <= 1'b0;
      bus.abort_out <= 1'b0;
    end else begin
      dclk_prev <= dclk_s;
      settle <= settled ? settle : settle + 1'b1;
      seen_cs_high <= state_n == IDLE && (seen_cs_high || (cs_s && settled));
      beat <= (state == IDLE) ? '0 : (state == SHIFT && rise && beat != LAST) ? beat + 1'b1 : beat;
      if (state == SHIFT && rise && beat != LAST) shift <= {shift[DATA_WIDTH-LINES-1:0], data_s};
      if (state == SHIFT && rise && beat == PEN) final_r <= final_s;
      bus.pixel_valid_out <= fire;
      bus.abort_out <= abort;
      bus.frame_done_out <= fire && final_r;
      if (fire) begin
        bus.pixel_out <= shift;
        bus.hcount_out <= h;
        bus.vcount_out <= v;
        h <= (final_r || h == H_LAST) ? '0 : h + 1'b1;
        v <= final_r ? '0 : (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 1'b1;
      end
    end
  end
`ifdef SPI_RX_ERR_COUNT_EN
  logic [15:0] err;
  always_ff @(posedge clk_in) begin
    if (rst_in) err <= '0;
    else if (abort && err != 16'hFFFF) err <= err + 1'b1;
  end
  assign bus.err_count_out = err;
`else
  assign bus.err_count_out = '0;
`endif
endmodule
